// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic library types
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first ripple-borrow subtractor
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            bin,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] d,
  output logic            bout
);

  localparam int CNT_W = $clog2(size + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(size - 1);

  sub_state_t      state_q, state_d;
  logic [size-1:0] ra_q, ra_d;
  logic [size-1:0] rb_q, rb_d;
  logic [size-1:0] rd_q, rd_d;
  logic            br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [size-1:0] d_q, d_d;
  logic            bout_q, bout_d;

  logic            diff;
  logic            bnext;
  logic [size:0]   rd_cat;

  full_subtractor u_cell (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .bin  (br_q),
    .d    (diff),
    .bout (bnext)
  );

  // New difference bit enters at the MSB so the result is aligned after size shifts
  assign rd_cat = {diff, rd_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          rd_d    = '0;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        rd_d  = rd_cat[size:1];
        br_d  = bnext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          d_d     = rd_cat[size:1];
          bout_d  = bnext;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule
